// File: rtl/buffer_rr_arbiter_pkg.sv
// Shared definitions for the buffered round-robin arbiter: index-width helper
// and the output-register state encoding.
package buffer_pkg;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

endpackage

// File: rtl/buffer_rr_arbiter_if.sv
// Requester-side and output-side valid/ready channels of buffer_rr_arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface buffer_rr_arbiter_if
  import buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 4
) ();

  localparam int unsigned IDX_WIDTH = clog2_min1(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic                          out_valid_o;
  logic [DATA_WIDTH-1:0]         out_data_o;
  logic [IDX_WIDTH-1:0]          out_src_o;
  logic                          out_ready_i;

  modport slave (
    input  req_valid_i,
    input  req_data_i,
    input  out_ready_i,
    output req_ready_o,
    output out_valid_o,
    output out_data_o,
    output out_src_o
  );

  modport master (
    output req_valid_i,
    output req_data_i,
    output out_ready_i,
    input  req_ready_o,
    input  out_valid_o,
    input  out_data_o,
    input  out_src_o
  );

endinterface

// File: rtl/buffer_rr_arbiter_rr.sv
// Combinational round-robin arbiter: the first requester strictly after
// last_grant wins, wrapping around to the lowest index.
module rr_arbiter
  import buffer_pkg::*;
#(
  parameter  int unsigned NUM_REQ   = 4,
  localparam int unsigned IDX_WIDTH = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] last_grant,
  output logic [NUM_REQ-1:0]   grant_onehot,
  output logic [IDX_WIDTH-1:0] grant_idx,
  output logic                 any
);

  logic [NUM_REQ-1:0]   w_mask;
  logic [2*NUM_REQ-1:0] w_dbl;
  logic                 w_found;

  always_comb begin
    w_mask = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_mask[k] = (k > 32'(last_grant));
    end
  end

  // Low half holds requesters above the pointer, high half the full set, so the
  // lowest set bit of the doubled vector is the wrapped round-robin winner.
  assign w_dbl = {req, req & w_mask};

  always_comb begin
    grant_idx = '0;
    w_found   = 1'b0;
    for (int unsigned i = 0; i < 2 * NUM_REQ; i++) begin
      if (!w_found && w_dbl[i]) begin
        w_found   = 1'b1;
        grant_idx = IDX_WIDTH'(i % NUM_REQ);
      end
    end
  end

  assign any = |req;

  always_comb begin
    grant_onehot = '0;
    if (any) begin
      grant_onehot[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/buffer_rr_arbiter.sv
// One shared output register stage fed by NUM_REQ valid/ready requesters under
// round-robin arbitration; each word is tagged with the index of its source.
module buffer_rr_arbiter
  import buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 4
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  buffer_rr_arbiter_if.slave  bus
);

  localparam int unsigned IDX_WIDTH = clog2_min1(NUM_REQ);

  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic [IDX_WIDTH-1:0]  r_src;
  logic [IDX_WIDTH-1:0]  r_last_grant;

  logic [NUM_REQ-1:0]    w_grant_onehot;
  logic [IDX_WIDTH-1:0]  w_grant_idx;
  logic                  w_any;
  logic                  w_load_en;
  logic                  w_load;
  logic                  w_drain;
  logic [DATA_WIDTH-1:0] w_sel_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req          (bus.req_valid_i),
    .last_grant   (r_last_grant),
    .grant_onehot (w_grant_onehot),
    .grant_idx    (w_grant_idx),
    .any          (w_any)
  );

  assign w_load_en = (r_state == ST_EMPTY) | bus.out_ready_i;
  assign w_load    = w_any & w_load_en;
  assign w_drain   = (r_state == ST_FULL) & bus.out_ready_i;

  always_comb begin
    w_sel_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_grant_onehot[k]) begin
        w_sel_data = bus.req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: w_state_nxt = w_load ? ST_FULL : ST_EMPTY;
      ST_FULL:  w_state_nxt = (w_drain && !w_load) ? ST_EMPTY : ST_FULL;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // Data and source are only written on a load, so a drain leaves them intact.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state      <= ST_EMPTY;
      r_data       <= '0;
      r_src        <= '0;
      r_last_grant <= IDX_WIDTH'(NUM_REQ - 1);
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_data       <= w_sel_data;
        r_src        <= w_grant_idx;
        r_last_grant <= w_grant_idx;
      end
    end
  end

  assign bus.req_ready_o = reset_n_i ? (w_grant_onehot & {NUM_REQ{w_load_en}}) : '0;
  assign bus.out_valid_o = (r_state == ST_FULL);
  assign bus.out_data_o  = r_data;
  assign bus.out_src_o   = r_src;

endmodule

// File: tb/tb_buffer_rr_arbiter.sv
// Directed bench for buffer_rr_arbiter: a vector table for the steady-state
// arbitration sequence plus hand-written reset, backpressure and fairness runs.
module tb_buffer_rr_arbiter;

  logic clk;
  logic rst_n;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  buffer_rr_arbiter_if #(.DATA_WIDTH(32), .NUM_REQ(4)) bus ();

  buffer_rr_arbiter #(
    .DATA_WIDTH (32),
    .NUM_REQ    (4)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  v;
    logic        rdy;
    logic [3:0]  er;
    logic        eov;
    logic [1:0]  es;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  // Drive at the falling edge, check ready combinationally, then check the
  // registered outputs just after the following rising edge.
  task automatic step(input string tag, input logic [3:0] v, input logic rdy,
                      input logic [3:0] er, input logic eov, input logic [1:0] es,
                      input logic [31:0] ed);
    @(negedge clk);
    bus.req_valid_i = v;
    bus.out_ready_i = rdy;
    #1;
    chk({tag, "_ready"}, 32'(bus.req_ready_o), 32'(er));
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 32'(bus.out_valid_o), 32'(eov));
    chk({tag, "_src"},   32'(bus.out_src_o),   32'(es));
    chk({tag, "_data"},  bus.out_data_o,       ed);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [1:0] exp_src;

  initial begin
    rst_n           = 1'b0;
    bus.req_valid_i = 4'b1111;
    bus.out_ready_i = 1'b1;
    bus.req_data_i  = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};

    // Reset state, with every requester valid
    #12;
    chk("rst_ready", 32'(bus.req_ready_o), 32'h0);
    chk("rst_valid", 32'(bus.out_valid_o), 32'h0);
    chk("rst_src",   32'(bus.out_src_o),   32'h0);
    chk("rst_data",  bus.out_data_o,       32'h0);
    @(negedge clk);
    bus.req_valid_i = 4'b0000;
    rst_n = 1'b1;

    tbl[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA5A5_0002};
    tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 32'hA5A5_0002};
    tbl[2]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA5A5_0003};
    tbl[3]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA5A5_0000};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA5A5_0001};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hA5A5_0002};
    tbl[6]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA5A5_0003};
    tbl[7]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA5A5_0001};
    tbl[8]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA5A5_0003};
    tbl[9]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'hA5A5_0001};
    tbl[10] = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA5A5_0003};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 32'hA5A5_0003};
    tbl[12] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3, 32'hA5A5_0003};
    tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 32'hA5A5_0003};
    tbl[14] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3, 32'hA5A5_0003};
    tbl[15] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 32'hA5A5_0003};
    tbl[16] = '{4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 32'hA5A5_0000};
    tbl[17] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 32'hA5A5_0000};
    tbl[18] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 32'hA5A5_0000};

    for (int i = 0; i < 19; i++) begin
      step($sformatf("vec%0d", i), tbl[i].v, tbl[i].rdy, tbl[i].er,
           tbl[i].eov, tbl[i].es, tbl[i].ed);
    end

    // Backpressure: hold src 1's word for three cycles, then drain+load src 3
    bus.req_data_i[63:32] = 32'h1111_0001;
    step("bp_load", 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h1111_0001);
    for (int i = 0; i < 3; i++) begin
      step($sformatf("bp_stall%0d", i), 4'b1010, 1'b0, 4'b0000, 1'b1, 2'd1, 32'h1111_0001);
    end
    step("bp_swap", 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA5A5_0003);
    bus.req_data_i[63:32] = 32'hA5A5_0001;

    // Fairness from reset: 0,1,2,3,0,1 with no bubbles
    bus.req_valid_i = 4'b0000;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      exp_src = 2'(i % 4);
      step($sformatf("fair%0d", i), 4'b1111, 1'b1, 4'b0001 << exp_src, 1'b1,
           exp_src, 32'hA5A5_0000 | 32'(exp_src));
    end

    // Reset asserted mid-cycle while the register is full
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.out_valid_o), 32'h0);
    chk("midrst_data",  bus.out_data_o,       32'h0);
    chk("midrst_src",   32'(bus.out_src_o),   32'h0);
    chk("midrst_ready", 32'(bus.req_ready_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
